// File: rtl/fir_pkg.sv
// Shared definitions for the FIR output path.
//   dec_state_t   : decimator control states
//   DATA_WIDTH, COEF_WIDTH, OUT_WIDTH : default widths of the filter chain
//   sat_to_width  : clamps a sign-extended sample to a signed range of 'width' bits
package fir_pkg;

    localparam int DATA_WIDTH = 16;
    localparam int COEF_WIDTH = 16;
    localparam int OUT_WIDTH  = 16;

    typedef enum logic [1:0] {
        WARMUP = 2'd0,
        RUN    = 2'd1
    } dec_state_t;

    // The result keeps the full 64-bit width so the caller can tell whether it clipped
    // by comparing it with the input. In-range values come back unchanged, so taking
    // the low 'width' bits keeps the sign.
    function automatic logic signed [63:0] sat_to_width(input logic signed [63:0] din,
                                                        input int width);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (width - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (width - 1));
        if (din > max_v) begin
            return max_v;
        end else if (din < min_v) begin
            return min_v;
        end
        return din;
    endfunction

endpackage

// File: rtl/fir_output_decimator_if.sv
// Valid/ready sample stream from the decimator to the next stage (DAC/packetiser).
//   out_data  : signed head-of-FIFO sample
//   out_valid : sample available
//   out_ready : sink accepts the sample this cycle
interface fir_output_decimator_if #(
    parameter int OUT_WIDTH = 16
);
    logic signed [OUT_WIDTH-1:0] out_data;
    logic                        out_valid;
    logic                        out_ready;

    modport master (output out_data, output out_valid, input out_ready);
    modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/fir_sample_fifo.sv
// Synchronous FIFO for decimated samples.
//   clock, reset_n : clock and async active-low reset
//   clear          : synchronous empty; takes priority over push and pop
//   push, wr_data  : write request and data; a push while full is ignored unless a pop happens in the same cycle
//   pop            : read request; ignored when empty
//   rd_data        : head entry (registered storage, no bypass)
//   full, empty    : occupancy flags
module fir_sample_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    // One extra pointer bit tells full apart from empty when the indices match.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rd_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
        end
    end

endmodule

// File: rtl/fir_output_decimator.sv
// Post-filter decimator. It discards the filter's warm-up samples, keeps 1 of every
// DECIMATION samples, saturates each kept sample to OUT_WIDTH, and queues it for a
// valid/ready sink.
//   clock, reset_n : clock shared with the filter, async active-low reset
//   filtered_data  : free-running signed filter output, one sample per clock
//   flush          : synchronous restart of warm-up and phase; also clears the FIFO and the status outputs
//   out_if         : valid/ready output stream (master side)
//   saturated      : sticky flag, set when a kept sample was clipped
//   drop_count     : kept samples lost because the FIFO was full; stops at all-ones
//
// state  | meaning
// WARMUP | discarding filter pipeline warm-up samples, no captures
// RUN    | phase counter cycling; capture when phase == 0
module fir_output_decimator #(
    parameter int IN_WIDTH      = 32,
    parameter int OUT_WIDTH     = 16,
    parameter int DECIMATION    = 4,
    parameter int WARMUP_CYCLES = 64,
    parameter int FIFO_DEPTH    = 4,
    parameter int DROP_WIDTH    = 16
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic signed [IN_WIDTH-1:0] filtered_data,
    input  logic                       flush,
    fir_output_decimator_if.master     out_if,
    output logic                       saturated,
    output logic [DROP_WIDTH-1:0]      drop_count
);
    import fir_pkg::*;

    localparam int PH_W = (DECIMATION > 1) ? $clog2(DECIMATION) : 1;
    localparam int WU_W = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(DECIMATION - 1);
    localparam logic [PH_W-1:0] PH_ONE  = PH_W'(1);
    localparam logic [WU_W-1:0] WU_LAST = WU_W'(WARMUP_CYCLES - 1);
    localparam logic [WU_W-1:0] WU_ONE  = WU_W'(1);
    localparam logic [DROP_WIDTH-1:0] DROP_ONE = DROP_WIDTH'(1);
    // With no warm-up, the first sample after reset is already a capture.
    localparam dec_state_t START_STATE = (WARMUP_CYCLES == 0) ? RUN : WARMUP;

    dec_state_t           state;
    logic [WU_W-1:0]      warm_cnt;
    logic [PH_W-1:0]      phase;
    logic                 cap_valid;
    logic [OUT_WIDTH-1:0] cap_data;
    logic signed [63:0]   din_ext;
    logic signed [63:0]   sat_val;
    logic                 clipped;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [OUT_WIDTH-1:0] fifo_rd_data;

    assign din_ext = 64'(filtered_data);
    assign sat_val = sat_to_width(din_ext, OUT_WIDTH);
    assign clipped = (sat_val != din_ext);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= START_STATE;
            warm_cnt  <= '0;
            phase     <= '0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
            saturated <= 1'b0;
        end else if (flush) begin
            state     <= START_STATE;
            warm_cnt  <= '0;
            phase     <= '0;
            cap_valid <= 1'b0;
            saturated <= 1'b0;
        end else begin
            cap_valid <= 1'b0;
            case (state)
                WARMUP: begin
                    if (warm_cnt == WU_LAST) begin
                        state    <= RUN;
                        warm_cnt <= '0;
                    end else begin
                        warm_cnt <= warm_cnt + WU_ONE;
                    end
                end
                RUN: begin
                    phase <= (phase == PH_LAST) ? '0 : phase + PH_ONE;
                    if (phase == '0) begin
                        cap_valid <= 1'b1;
                        cap_data  <= sat_val[OUT_WIDTH-1:0];
                        if (clipped) begin
                            saturated <= 1'b1;
                        end
                    end
                end
                default: state <= START_STATE;
            endcase
        end
    end

    assign fifo_pop = out_if.out_valid && out_if.out_ready;

    // A pop in the same cycle frees a slot, so a push into a full FIFO only drops when there is no pop.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (flush) begin
            drop_count <= '0;
        end else if (cap_valid && fifo_full && !fifo_pop && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_ONE;
        end
    end

    fir_sample_fifo #(
        .WIDTH (OUT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (flush),
        .push    (cap_valid),
        .wr_data (cap_data),
        .pop     (fifo_pop),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign out_if.out_data  = fifo_rd_data;
    assign out_if.out_valid = !fifo_empty;

endmodule

// File: tb/tb_fir_output_decimator.sv
module tb_fir_output_decimator;
    localparam int DEC = 4;
    localparam int WU  = 8;

    logic               clock = 1'b0;
    logic               reset_n = 1'b0;
    logic               flush = 1'b0;
    logic signed [31:0] filtered_data = '0;
    logic               saturated;
    logic [15:0]        drop_count;

    fir_output_decimator_if #(.OUT_WIDTH(16)) out_if ();

    fir_output_decimator #(
        .IN_WIDTH      (32),
        .OUT_WIDTH     (16),
        .DECIMATION    (DEC),
        .WARMUP_CYCLES (WU),
        .FIFO_DEPTH    (4),
        .DROP_WIDTH    (16)
    ) dut (
        .clock         (clock),
        .reset_n       (reset_n),
        .filtered_data (filtered_data),
        .flush         (flush),
        .out_if        (out_if),
        .saturated     (saturated),
        .drop_count    (drop_count)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          m_cnt;
    bit          m_cap_valid;
    logic [15:0] m_cap_data;
    bit          m_sat;
    int          m_drop;
    logic [15:0] exp_q[$];
    logic [15:0] got_q[$];

    function automatic logic [15:0] model_sat(input logic signed [31:0] d);
        if (d > 32767) return 16'h7FFF;
        if (d < -32768) return 16'h8000;
        return d[15:0];
    endfunction

    task automatic model_clear();
        m_cnt = 0;
        m_cap_valid = 0;
        m_cap_data = '0;
        m_sat = 0;
        m_drop = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        flush = 1'b0;
        out_if.out_ready = 1'b1;
        filtered_data = '0;
        model_clear();
        got_q.delete();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    // One clock: drive inputs, score a pop before the edge, advance the model, check status after.
    task automatic step(input logic signed [31:0] d, input logic rdy, input logic fl);
        bit popped;
        bit was_full;
        bit kept;
        @(negedge clock);
        filtered_data = d;
        out_if.out_ready = rdy;
        flush = fl;
        #1;
        if (!fl && rdy && exp_q.size() != 0) begin
            checks++;
            if (out_if.out_data !== exp_q[0]) begin
                failures++;
                $display("FAIL pop_data: got %h expected %h", out_if.out_data, exp_q[0]);
            end
            got_q.push_back(out_if.out_data);
        end
        @(posedge clock);
        #1;
        if (fl) begin
            model_clear();
        end else begin
            popped = rdy && (exp_q.size() != 0);
            was_full = (exp_q.size() == 4);
            if (popped) void'(exp_q.pop_front());
            if (m_cap_valid) begin
                if (was_full && !popped) begin
                    if (m_drop < 65535) m_drop++;
                end else begin
                    exp_q.push_back(m_cap_data);
                end
            end
            kept = (m_cnt >= WU) && (((m_cnt - WU) % DEC) == 0);
            m_cap_valid = kept;
            if (kept) begin
                m_cap_data = model_sat(d);
                if (d > 32767 || d < -32768) m_sat = 1;
            end
            m_cnt++;
        end
        checks++;
        if (out_if.out_valid !== (exp_q.size() != 0)) begin
            failures++;
            $display("FAIL out_valid: got %b expected %b", out_if.out_valid, exp_q.size() != 0);
        end
        checks++;
        if (saturated !== m_sat) begin
            failures++;
            $display("FAIL saturated: got %b expected %b", saturated, m_sat);
        end
        checks++;
        if (drop_count !== 16'(m_drop)) begin
            failures++;
            $display("FAIL drop_count: got %0d expected %0d", drop_count, m_drop);
        end
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (out_if.out_valid !== 1'b0 || out_if.out_data !== 16'h0 ||
            saturated !== 1'b0 || drop_count !== 16'h0) begin
            failures++;
            $display("FAIL reset_state: got valid=%b data=%h sat=%b drop=%0d expected 0/0000/0/0",
                     out_if.out_valid, out_if.out_data, saturated, drop_count);
        end
    endtask

    task automatic test_warmup_decimation();
        logic [15:0] exp_first[4] = '{16'd8, 16'd12, 16'd16, 16'd20};
        do_reset();
        for (int k = 0; k <= 40; k++) begin
            step(k, 1'b1, 1'b0);
            if (k == 8) begin
                checks++;
                if (out_if.out_valid !== 1'b0) begin
                    failures++;
                    $display("FAIL latency_early: got valid=%b expected 0", out_if.out_valid);
                end
            end
            if (k == 9) begin
                checks++;
                if (out_if.out_valid !== 1'b1 || out_if.out_data !== 16'd8) begin
                    failures++;
                    $display("FAIL latency_first: got valid=%b data=%0d expected 1/8",
                             out_if.out_valid, out_if.out_data);
                end
            end
        end
        checks++;
        if (got_q.size() < 4) begin
            failures++;
            $display("FAIL decim_count: got %0d outputs expected at least 4", got_q.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (got_q[i] !== exp_first[i]) begin
                    failures++;
                    $display("FAIL decim_seq[%0d]: got %0d expected %0d", i, got_q[i], exp_first[i]);
                end
            end
        end
    endtask

    task automatic test_saturation();
        logic signed [31:0] vals[3] = '{32'sh0001_2345, 32'shFFFF_0000, 32'sh0000_1234};
        logic [15:0]        exp_o[3] = '{16'h7FFF, 16'h8000, 16'h1234};
        do_reset();
        for (int k = 0; k < WU; k++) step(0, 1'b1, 1'b0);
        for (int v = 0; v < 3; v++) begin
            for (int k = 0; k < DEC; k++) step(vals[v], 1'b1, 1'b0);
            if (v == 0) begin
                checks++;
                if (saturated !== 1'b1) begin
                    failures++;
                    $display("FAIL sat_set: got %b expected 1", saturated);
                end
            end
        end
        for (int k = 0; k < 6; k++) step(0, 1'b1, 1'b0);
        checks++;
        if (saturated !== 1'b1) begin
            failures++;
            $display("FAIL sat_sticky: got %b expected 1", saturated);
        end
        checks++;
        if (got_q.size() < 3) begin
            failures++;
            $display("FAIL sat_count: got %0d outputs expected at least 3", got_q.size());
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (got_q[i] !== exp_o[i]) begin
                    failures++;
                    $display("FAIL sat_value[%0d]: got %h expected %h", i, got_q[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] exp_o[5] = '{16'd8, 16'd12, 16'd16, 16'd20, 16'd32};
        do_reset();
        for (int k = 0; k < 30; k++) begin
            step(k, 1'b0, 1'b0);
            if (k >= 10) begin
                checks++;
                if (out_if.out_data !== 16'd8) begin
                    failures++;
                    $display("FAIL bp_hold: got %0d expected 8", out_if.out_data);
                end
            end
        end
        checks++;
        if (drop_count !== 16'd2) begin
            failures++;
            $display("FAIL bp_drops: got %0d expected 2", drop_count);
        end
        for (int k = 30; k <= 50; k++) step(k, 1'b1, 1'b0);
        checks++;
        if (got_q.size() < 5) begin
            failures++;
            $display("FAIL bp_count: got %0d outputs expected at least 5", got_q.size());
        end else begin
            for (int i = 0; i < 5; i++) begin
                checks++;
                if (got_q[i] !== exp_o[i]) begin
                    failures++;
                    $display("FAIL bp_drain[%0d]: got %0d expected %0d", i, got_q[i], exp_o[i]);
                end
            end
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int k = 0; k < 25; k++) step(k, 1'b0, 1'b0);
        step(25, 1'b1, 1'b0);
        checks++;
        if (drop_count !== 16'd0 || out_if.out_valid !== 1'b1 || out_if.out_data !== 16'd12) begin
            failures++;
            $display("FAIL full_pop: got drop=%0d valid=%b data=%0d expected 0/1/12",
                     drop_count, out_if.out_valid, out_if.out_data);
        end
        for (int k = 26; k < 30; k++) step(k, 1'b0, 1'b0);
        checks++;
        if (drop_count !== 16'd1) begin
            failures++;
            $display("FAIL full_pop_occ: got drop=%0d expected 1", drop_count);
        end
        for (int k = 30; k < 42; k++) step(k, 1'b1, 1'b0);
        checks++;
        if (got_q.size() < 5 || got_q[4] !== 16'd24) begin
            failures++;
            $display("FAIL full_pop_kept: got %0d outputs, fifth=%0d expected fifth 24",
                     got_q.size(), (got_q.size() >= 5) ? got_q[4] : 16'hFFFF);
        end
    endtask

    task automatic test_flush();
        do_reset();
        for (int k = 0; k < 18; k++) step((k == 8) ? 32'sh0001_2345 : k, 1'b0, 1'b0);
        checks++;
        if (out_if.out_valid !== 1'b1 || saturated !== 1'b1) begin
            failures++;
            $display("FAIL flush_pre: got valid=%b sat=%b expected 1/1", out_if.out_valid, saturated);
        end
        step(200, 1'b1, 1'b1);
        checks++;
        if (out_if.out_valid !== 1'b0 || saturated !== 1'b0 || drop_count !== 16'd0) begin
            failures++;
            $display("FAIL flush_clear: got valid=%b sat=%b drop=%0d expected 0/0/0",
                     out_if.out_valid, saturated, drop_count);
        end
        got_q.delete();
        for (int p = 0; p <= 12; p++) step(100 + p, 1'b1, 1'b0);
        checks++;
        if (got_q.size() < 1 || got_q[0] !== 16'd108) begin
            failures++;
            $display("FAIL flush_restart: got %0d outputs, first=%0d expected first 108",
                     got_q.size(), (got_q.size() >= 1) ? got_q[0] : 16'hFFFF);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int k = 0; k < 30; k++) step(32'sh0001_2345, 1'b0, 1'b0);
        checks++;
        if (out_if.out_valid !== 1'b1 || drop_count !== 16'd2 || saturated !== 1'b1) begin
            failures++;
            $display("FAIL async_pre: got valid=%b drop=%0d sat=%b expected 1/2/1",
                     out_if.out_valid, drop_count, saturated);
        end
        @(posedge clock);
        #3;
        reset_n = 1'b0;
        #1;
        checks++;
        if (out_if.out_valid !== 1'b0 || out_if.out_data !== 16'h0 ||
            drop_count !== 16'd0 || saturated !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got valid=%b data=%h drop=%0d sat=%b expected 0/0000/0/0",
                     out_if.out_valid, out_if.out_data, drop_count, saturated);
        end
        model_clear();
        @(posedge clock);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        out_if.out_ready = 1'b1;
        model_clear();
        test_reset();
        test_warmup_decimation();
        test_saturation();
        test_backpressure();
        test_full_pop();
        test_flush();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
